// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with non-preemptive grants and a hold limit
// Fully registered outputs; the rotating pointer moves past the last grantee on every release.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] pick_idx;
  logic       pick_any;
  logic [2:0] cand;
  logic       req_held;
  logic       hold_hit;
  logic       release_now;
  logic       timeout_cause;

  // Walk offsets from 7 down to 0 so the candidate nearest ptr wins.
  always_comb begin
    pick_idx = 3'd0;
    pick_any = 1'b0;
    cand     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_idx = cand;
        pick_any = 1'b1;
      end
    end
  end

  always_comb begin
    req_held      = req[gnt_idx];
    hold_hit      = (hold_cnt == HOLD_LAST);
    release_now   = done || !req_held || hold_hit;
    timeout_cause = hold_hit && !done && req_held;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= 8'd0;
      ptr       <= 3'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            gnt       <= 8'b1 << pick_idx;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= timeout_cause;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - table-driven scoreboard bench for rr_arbiter_8
// Two instances share stimulus: default HOLD_MAX and HOLD_MAX = 4.
module tb_rr_arbiter_8;

  typedef struct {
    logic       sel;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;

  logic [7:0] gnt15, gnt4;
  logic [2:0] idx15, idx4;
  logic       valid15, valid4;
  logic       to15, to4;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   row = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 u_dut15 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt15), .gnt_idx(idx15), .gnt_valid(valid15), .timeout(to15)
  );

  rr_arbiter_8 #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(valid4), .timeout(to4)
  );

  task automatic add(input logic sel, input logic r, input logic [7:0] rq, input logic d,
                     input logic [2:0] idx, input logic valid, input logic to);
    vec_t v;
    v.sel = sel; v.rst = r; v.req = rq; v.done = d;
    v.idx = idx; v.valid = valid; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] g, eg;
    logic [2:0] i;
    logic       v, t;
    e = exp_q.pop_front();
    if (e.sel) begin
      g = gnt15; i = idx15; v = valid15; t = to15;
    end else begin
      g = gnt4; i = idx4; v = valid4; t = to4;
    end
    eg = e.valid ? (8'b1 << e.idx) : 8'h00;
    cmp(e.sel ? "gnt15" : "gnt4", g, eg);
    cmp(e.sel ? "idx15" : "idx4", {5'b0, i}, {5'b0, e.idx});
    cmp(e.sel ? "valid15" : "valid4", {7'b0, v}, {7'b0, e.valid});
    cmp(e.sel ? "timeout15" : "timeout4", {7'b0, t}, {7'b0, e.to});
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; req = v.req; done = v.done;
    e.sel = v.sel; e.idx = v.idx; e.valid = v.valid; e.to = v.to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    row++;
  endtask

  initial begin
    // HOLD_MAX = 4 instance: grant, release causes, idle done, timeout, done at limit
    add(0, 1, 8'hFF, 1, 0, 0, 0);
    add(0, 0, 8'hA0, 0, 5, 1, 0);
    add(0, 0, 8'hA0, 0, 5, 1, 0);
    add(0, 0, 8'hA0, 1, 0, 0, 0);
    add(0, 0, 8'hA0, 0, 7, 1, 0);
    add(0, 0, 8'h20, 0, 0, 0, 0);
    add(0, 0, 8'h81, 0, 0, 1, 0);
    add(0, 0, 8'h81, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 8'h08, 0, 3, 1, 0);
    add(0, 0, 8'h08, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 0, 8'h08, 0, 3, 1, 0);
    add(0, 0, 8'h08, 1, 0, 0, 0);
    // full rotation from reset
    add(0, 1, 8'hFF, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      add(0, 0, 8'hFF, 0, 3'(k % 8), 1, 0);
      add(0, 0, 8'hFF, 1, 0, 0, 0);
    end
    // reset mid-grant
    add(0, 0, 8'h40, 0, 6, 1, 0);
    add(0, 0, 8'h40, 0, 6, 1, 0);
    add(0, 1, 8'h40, 0, 0, 0, 0);
    add(0, 0, 8'h41, 0, 0, 1, 0);
    add(0, 0, 8'h41, 1, 0, 0, 0);
    // request drop coinciding with the hold limit
    for (int k = 0; k < 4; k++) add(0, 0, 8'h08, 0, 3, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0);

    foreach (tbl[n]) apply(tbl[n]);

    // default HOLD_MAX instance: first grant and full 15-cycle hold
    begin
      vec_t v;
      v.sel = 1; v.rst = 1; v.req = 8'h00; v.done = 0; v.idx = 0; v.valid = 0; v.to = 0;
      apply(v);
      v.rst = 0; v.req = 8'hA0; v.idx = 5; v.valid = 1;
      apply(v);
      v.done = 1; v.idx = 0; v.valid = 0;
      apply(v);
      v.rst = 1; v.req = 8'h00; v.done = 0;
      apply(v);
      v.rst = 0; v.req = 8'h08; v.idx = 3; v.valid = 1;
      for (int k = 0; k < 15; k++) apply(v);
      v.idx = 0; v.valid = 0; v.to = 1;
      apply(v);
      v.idx = 3; v.valid = 1; v.to = 0;
      apply(v);
      v.done = 1; v.idx = 0; v.valid = 0;
      apply(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
